// File: rtl/aging_uart_tx_if.sv
// Sample-to-UART handshake bundle: start request and sample word in, serial line and status out.
interface aging_uart_tx_if #(
    parameter int DATA_W = 16
);
    logic              uart_start;
    logic [DATA_W-1:0] sample_data;
    logic              tx;
    logic              busy;
    logic              done;
    logic              overrun;

    modport master (
        output uart_start,
        output sample_data,
        input  tx,
        input  busy,
        input  done,
        input  overrun
    );

    modport slave (
        input  uart_start,
        input  sample_data,
        output tx,
        output busy,
        output done,
        output overrun
    );
endinterface

// File: rtl/aging_uart_tx.sv
// Aging-sensor sample serialiser: ceil(DATA_W/8) bytes, LSB byte/bit first, 8N1 line framing.
// Define UART_PARITY_EN to insert an even-parity bit after each data byte (8E1).
module aging_uart_tx #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    aging_uart_tx_if.slave    bus
);

    localparam int NB = (DATA_W + 7) / 8;
    localparam int SW = NB * 8;
    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NB > 0) ? $clog2(NB + 1) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [IW-1:0] BYTE_LAST = IW'(NB - 1);
    localparam logic [IW-1:0] BYTE_ONE  = IW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

`ifdef UART_PARITY_EN
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q,  baud_d;
    logic [2:0]      bit_q,   bit_d;
    logic [IW-1:0]   byte_q,  byte_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic            tx_q,    tx_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic            overrun_q, overrun_d;

    logic [SW-1:0]   padded_s;
    logic [7:0]      cur_byte_s;
    logic            bit_end_s;

    // Zero-extend the sample to a whole number of bytes.
    always_comb begin
        padded_s                = '0;
        padded_s[DATA_W-1:0]    = bus.sample_data;
    end

    assign cur_byte_s = shift_q[7:0];
    assign bit_end_s  = (baud_q == BAUD_LAST);

    // Next-state, counters and output values; tx is derived from the current state so it lags by one cycle.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;
        done_d    = 1'b0;
        overrun_d = bus.uart_start && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (bus.uart_start) begin
                    shift_d = padded_s;
                    byte_d  = '0;
                    bit_d   = 3'd0;
                    baud_d  = '0;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_end_s) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d  = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                tx_d = cur_byte_s[bit_q];
                if (bit_end_s) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                tx_d = even_parity(cur_byte_s);
                if (bit_end_s) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d  = baud_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end_s) begin
                    baud_d = '0;
                    // Last byte ends the sequence; otherwise the next start bit follows with no gap.
                    if (byte_q == BYTE_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        byte_d  = byte_q + BYTE_ONE;
                        shift_d = shift_q >> 4'd8;
                        state_d = S_START;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers; async reset parks the line high immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= 3'd0;
            byte_q    <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.overrun = overrun_q;

endmodule
